instruction_issue_unit: RTL and testbench
=========================================

INSTRUCTION_ISSUE_UNIT -- requirements
Module: instruction_issue_unit

Interface
REQ-001 SHALL have port clk_in  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port rst_in  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port rdy_in  input  1  when low, all state holds and no new request starts.
REQ-004 SHALL have fetch ports: fetch_req  output  1 (request); fetch_addr  output  32 (word address); fetch_done  input  1 (one-cycle response pulse); fetch_data  input  32 (instruction, valid with fetch_done).
REQ-005 SHALL have port csu_full  input  1  scheduler cannot accept an instruction this cycle.
REQ-006 SHALL have ports flush_pipline  input  1 and flush_target_pc  input  32  redirect fetch.
REQ-007 SHALL have issue ports, all outputs: ins_just_issued 1, issue_PC 32, ins_issued 32, issue_opcode 7, issue_funct3 3, issue_funct7 7, issue_imm_val 32, issue_shamt_val 6, issue_rs1 5, issue_rs2 5, issue_rd 5.

Function
REQ-008 SHALL use FSM states IDLE, WAIT_MEM, HOLD.
- IDLE -> WAIT_MEM: rdy_in high and no flush; assert fetch_req with fetch_addr=pc.
- WAIT_MEM -> HOLD: on fetch_done; latch fetch_data.
- HOLD -> IDLE: on issue.
REQ-009 SHALL keep fetch_req and fetch_addr stable from assertion until fetch_done; a request is never withdrawn.
REQ-010 SHALL issue from HOLD when csu_full low and rdy_in high: ins_just_issued high exactly one cycle with all issue_* fields registered and valid in that cycle.
REQ-011 SHALL give one-cycle latency: fetch_done in cycle N with csu_full low -> ins_just_issued in cycle N+1.
REQ-012 SHALL stall in HOLD while csu_full is high, with no further fetch issued.
REQ-013 SHALL decode fields: opcode=ins[6:0], rd=ins[11:7], funct3=ins[14:12], rs1=ins[19:15], rs2=ins[24:20], funct7=ins[31:25], shamt=ins[25:20].
REQ-014 SHALL sign-extend imm by opcode: I-type(0010011, 0000011, 1100111); S(0100011); B(1100011, bit0=0); U(0110111, 0010111, low 12 zero); J(1101111, bit0=0); other opcodes imm=0.
REQ-015 SHALL advance pc to pc+4 on issue, modulo 2^32 (0xFFFFFFFC wraps to 0x0).
REQ-016 SHALL, on flush_pipline in any state:
- set pc=flush_target_pc;
- drop any HOLD instruction (no issue that cycle);
- go to IDLE.
Flush has priority over a simultaneous issue.
REQ-017 SHALL, on flush during WAIT_MEM, stay in WAIT_MEM with a discard flag set, drop the next fetch_done data, then refetch from the new pc.
REQ-018 SHALL treat fetch_done coincident with flush as discarded.

Reset
REQ-019 SHALL on rst_in low:
- set pc=0x00000000, state IDLE, discard flag 0;
- set fetch_req=0, fetch_addr=0, ins_just_issued=0;
- set all issue_* outputs to 0.
REQ-020 SHALL on reset mid-request ignore any later fetch_done for the pre-reset request until a new request is made.

Configuration
REQ-021 SHALL, with ISSUE_JAL_PREDICT_EN defined, set next pc=pc+imm (J-type) on issue of opcode 1101111 instead of pc+4.
REQ-022 SHALL, without ISSUE_JAL_PREDICT_EN, always advance pc by 4 on issue; decode and issue outputs are identical in both builds.

Verification
REQ-023 SHALL cover: reset, fetch_data=0x00500093 at pc 0 -> issue opcode 0x13, rd=1, rs1=0, imm=5, issue_PC=0, next fetch_addr=4.
REQ-024 SHALL cover: csu_full high 5 cycles after fetch_done -> ins_just_issued low throughout, then single pulse the cycle after csu_full drops.
REQ-025 SHALL cover: flush (target 0x100) during WAIT_MEM -> returned data dropped, next fetch_addr=0x100, no issue of old instruction.
REQ-026 SHALL cover: flush same cycle as HOLD issue -> no ins_just_issued, next fetch_addr=target.
REQ-027 SHALL cover: fetch_data=0xFE000EE3 (beq, B-imm -4) -> issue_imm_val=0xFFFFFFFC; JAL 0x0080006F at pc 0x20 -> next fetch 0x28 with ISSUE_JAL_PREDICT_EN, 0x24 without.
REQ-028 SHALL cover: rdy_in low 3 cycles in WAIT_MEM and HOLD -> all outputs frozen, resume unchanged.

Source files
------------

// File: rtl/instruction_issue_unit.sv
// instruction_issue_unit: fetches one instruction at a time, decodes it and issues it to the scheduler.
// Optional macro ISSUE_JAL_PREDICT_EN: a JAL issue redirects the next fetch to its jump target.
`default_nettype none

module instruction_issue_unit (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_done,
   input  logic [31:0] fetch_data,
   input  logic        csu_full,
   input  logic        flush_pipline,
   input  logic [31:0] flush_target_pc,
   output logic        ins_just_issued,
   output logic [31:0] issue_PC,
   output logic [31:0] ins_issued,
   output logic [6:0]  issue_opcode,
   output logic [2:0]  issue_funct3,
   output logic [6:0]  issue_funct7,
   output logic [31:0] issue_imm_val,
   output logic [5:0]  issue_shamt_val,
   output logic [4:0]  issue_rs1,
   output logic [4:0]  issue_rs2,
   output logic [4:0]  issue_rd
);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      HOLD     = 2'd2
   } state_t;

   function automatic logic [31:0] decode_imm(input logic [31:0] ins);
      logic [31:0] imm;
      case (ins[6:0])
         OP_IMM, OP_LOAD, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
         OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
         OP_JAL:                   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                  imm = 32'd0;
      endcase
      return imm;
   endfunction

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic        fetch_req_q, fetch_req_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic [31:0] ins_q, ins_d;
   logic        just_issued_q, just_issued_d;
   logic [31:0] issue_pc_q, issue_pc_d;
   logic [31:0] issue_ins_q, issue_ins_d;
   logic [31:0] issue_imm_q, issue_imm_d;

   logic        do_issue;
   logic [31:0] issue_src;
   logic [31:0] issue_imm;

   // A fresh response with room downstream issues straight from fetch_data, skipping HOLD.
   assign issue_src = (state_q == HOLD) ? ins_q : fetch_data;
   assign issue_imm = decode_imm(issue_src);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      discard_d     = discard_q;
      fetch_req_d   = fetch_req_q;
      fetch_addr_d  = fetch_addr_q;
      ins_d         = ins_q;
      just_issued_d = 1'b0;
      issue_pc_d    = issue_pc_q;
      issue_ins_d   = issue_ins_q;
      issue_imm_d   = issue_imm_q;
      do_issue      = 1'b0;

      if (rdy_in) begin
         if (flush_pipline) begin
            pc_d = flush_target_pc;
            if (state_q == WAIT_MEM) begin
               if (fetch_done) begin
                  state_d     = IDLE;
                  fetch_req_d = 1'b0;
                  discard_d   = 1'b0;
               end else begin
                  // The outstanding request cannot be withdrawn; swallow its reply instead.
                  discard_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  state_d      = WAIT_MEM;
                  fetch_req_d  = 1'b1;
                  fetch_addr_d = pc_q;
               end
               WAIT_MEM: begin
                  if (fetch_done) begin
                     fetch_req_d = 1'b0;
                     if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                     end else if (!csu_full) begin
                        do_issue = 1'b1;
                        state_d  = IDLE;
                     end else begin
                        ins_d   = fetch_data;
                        state_d = HOLD;
                     end
                  end
               end
               HOLD: begin
                  if (!csu_full) begin
                     do_issue = 1'b1;
                     state_d  = IDLE;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end

      if (do_issue) begin
         just_issued_d = 1'b1;
         issue_pc_d    = pc_q;
         issue_ins_d   = issue_src;
         issue_imm_d   = issue_imm;
`ifdef ISSUE_JAL_PREDICT_EN
         pc_d = (issue_src[6:0] == OP_JAL) ? pc_q + issue_imm : pc_q + 32'd4;
`else
         pc_d = pc_q + 32'd4;
`endif
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q       <= IDLE;
         pc_q          <= 32'd0;
         discard_q     <= 1'b0;
         fetch_req_q   <= 1'b0;
         fetch_addr_q  <= 32'd0;
         ins_q         <= 32'd0;
         just_issued_q <= 1'b0;
         issue_pc_q    <= 32'd0;
         issue_ins_q   <= 32'd0;
         issue_imm_q   <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         discard_q     <= discard_d;
         fetch_req_q   <= fetch_req_d;
         fetch_addr_q  <= fetch_addr_d;
         ins_q         <= ins_d;
         just_issued_q <= just_issued_d;
         issue_pc_q    <= issue_pc_d;
         issue_ins_q   <= issue_ins_d;
         issue_imm_q   <= issue_imm_d;
      end
   end

   assign fetch_req       = fetch_req_q;
   assign fetch_addr      = fetch_addr_q;
   assign ins_just_issued = just_issued_q;
   assign issue_PC        = issue_pc_q;
   assign ins_issued      = issue_ins_q;
   assign issue_imm_val   = issue_imm_q;
   // Field slices come straight off the registered instruction word.
   assign issue_opcode    = issue_ins_q[6:0];
   assign issue_rd        = issue_ins_q[11:7];
   assign issue_funct3    = issue_ins_q[14:12];
   assign issue_rs1       = issue_ins_q[19:15];
   assign issue_rs2       = issue_ins_q[24:20];
   assign issue_funct7    = issue_ins_q[31:25];
   assign issue_shamt_val = issue_ins_q[25:20];

endmodule

`default_nettype wire

// File: tb/tb_instruction_issue_unit.sv
// Directed self-checking bench for instruction_issue_unit; stimulus and checks happen on the falling edge.
`default_nettype none

module tb_instruction_issue_unit;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_done;
   logic [31:0] fetch_data;
   logic        csu_full;
   logic        flush_pipline;
   logic [31:0] flush_target_pc;
   logic        ins_just_issued;
   logic [31:0] issue_PC;
   logic [31:0] ins_issued;
   logic [6:0]  issue_opcode;
   logic [2:0]  issue_funct3;
   logic [6:0]  issue_funct7;
   logic [31:0] issue_imm_val;
   logic [5:0]  issue_shamt_val;
   logic [4:0]  issue_rs1;
   logic [4:0]  issue_rs2;
   logic [4:0]  issue_rd;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] jal_next;

   instruction_issue_unit dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .fetch_req       (fetch_req),
      .fetch_addr      (fetch_addr),
      .fetch_done      (fetch_done),
      .fetch_data      (fetch_data),
      .csu_full        (csu_full),
      .flush_pipline   (flush_pipline),
      .flush_target_pc (flush_target_pc),
      .ins_just_issued (ins_just_issued),
      .issue_PC        (issue_PC),
      .ins_issued      (ins_issued),
      .issue_opcode    (issue_opcode),
      .issue_funct3    (issue_funct3),
      .issue_funct7    (issue_funct7),
      .issue_imm_val   (issue_imm_val),
      .issue_shamt_val (issue_shamt_val),
      .issue_rs1       (issue_rs1),
      .issue_rs2       (issue_rs2),
      .issue_rd        (issue_rd)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      @(negedge clk_in);
   endtask

   // Present one response pulse, then leave the bench on the falling edge after it.
   task automatic respond(input logic [31:0] data);
      fetch_done = 1'b1;
      fetch_data = data;
      tick();
      fetch_done = 1'b0;
      fetch_data = 32'd0;
   endtask

   initial begin
`ifdef ISSUE_JAL_PREDICT_EN
      jal_next = 32'h28;
`else
      jal_next = 32'h24;
`endif
      rst_in = 1'b0; rdy_in = 1'b1; fetch_done = 1'b0; fetch_data = 32'd0;
      csu_full = 1'b0; flush_pipline = 1'b0; flush_target_pc = 32'd0;
      tick(); tick();
      chk("rst_req",   {31'd0, fetch_req}, 32'd0);
      chk("rst_addr",  fetch_addr, 32'd0);
      chk("rst_iss",   {31'd0, ins_just_issued}, 32'd0);
      chk("rst_pc",    issue_PC, 32'd0);
      chk("rst_ins",   ins_issued, 32'd0);
      chk("rst_imm",   issue_imm_val, 32'd0);
      rst_in = 1'b1;
      tick();
      chk("req0",      {31'd0, fetch_req}, 32'd1);
      chk("req0_addr", fetch_addr, 32'd0);

      // addi x1, x0, 5 issues one cycle after the response
      respond(32'h0050_0093);
      chk("a_iss",    {31'd0, ins_just_issued}, 32'd1);
      chk("a_op",     {25'd0, issue_opcode}, 32'h13);
      chk("a_rd",     {27'd0, issue_rd}, 32'd1);
      chk("a_rs1",    {27'd0, issue_rs1}, 32'd0);
      chk("a_f3",     {29'd0, issue_funct3}, 32'd0);
      chk("a_imm",    issue_imm_val, 32'd5);
      chk("a_pc",     issue_PC, 32'd0);
      chk("a_shamt",  {26'd0, issue_shamt_val}, 32'd5);
      chk("a_req",    {31'd0, fetch_req}, 32'd0);
      tick();
      chk("a_pulse",  {31'd0, ins_just_issued}, 32'd0);
      chk("a_next",   fetch_addr, 32'd4);
      chk("a_nreq",   {31'd0, fetch_req}, 32'd1);

      // scheduler full for 5 cycles after the response
      csu_full = 1'b1;
      respond(32'h00A0_0113);
      for (int i = 0; i < 5; i++) begin
         chk("full_iss", {31'd0, ins_just_issued}, 32'd0);
         chk("full_req", {31'd0, fetch_req}, 32'd0);
         tick();
      end
      csu_full = 1'b0;
      tick();
      chk("full_pulse", {31'd0, ins_just_issued}, 32'd1);
      chk("full_pc",    issue_PC, 32'd4);
      chk("full_imm",   issue_imm_val, 32'd10);
      chk("full_rd",    {27'd0, issue_rd}, 32'd2);
      tick();
      chk("full_once",  {31'd0, ins_just_issued}, 32'd0);
      chk("full_next",  fetch_addr, 32'd8);

      // flush during WAIT_MEM: request stays up, late reply is dropped
      flush_pipline = 1'b1; flush_target_pc = 32'h100;
      tick();
      flush_pipline = 1'b0;
      chk("fw_req",   {31'd0, fetch_req}, 32'd1);
      chk("fw_addr",  fetch_addr, 32'd8);
      tick();
      respond(32'h0010_0093);
      chk("fw_noiss", {31'd0, ins_just_issued}, 32'd0);
      tick();
      chk("fw_iss2",  {31'd0, ins_just_issued}, 32'd0);
      chk("fw_next",  fetch_addr, 32'h100);
      chk("fw_nreq",  {31'd0, fetch_req}, 32'd1);

      // flush in the same cycle HOLD would issue
      csu_full = 1'b1;
      respond(32'h0030_0193);
      csu_full = 1'b0; flush_pipline = 1'b1; flush_target_pc = 32'h200;
      tick();
      flush_pipline = 1'b0;
      chk("fh_noiss", {31'd0, ins_just_issued}, 32'd0);
      chk("fh_oldpc", issue_PC, 32'd4);
      tick();
      chk("fh_next",  fetch_addr, 32'h200);

      // beq with B-immediate -4
      respond(32'hFE00_0EE3);
      chk("b_iss",  {31'd0, ins_just_issued}, 32'd1);
      chk("b_op",   {25'd0, issue_opcode}, 32'h63);
      chk("b_imm",  issue_imm_val, 32'hFFFF_FFFC);
      chk("b_pc",   issue_PC, 32'h200);
      tick();
      chk("b_next", fetch_addr, 32'h204);

      // response coincident with flush is discarded, then JAL at 0x20
      flush_pipline = 1'b1; flush_target_pc = 32'h20;
      respond(32'h0050_0093);
      flush_pipline = 1'b0;
      chk("fc_noiss", {31'd0, ins_just_issued}, 32'd0);
      tick();
      chk("fc_next",  fetch_addr, 32'h20);
      respond(32'h0080_006F);
      chk("j_iss",  {31'd0, ins_just_issued}, 32'd1);
      chk("j_op",   {25'd0, issue_opcode}, 32'h6F);
      chk("j_imm",  issue_imm_val, 32'd8);
      chk("j_pc",   issue_PC, 32'h20);
      tick();
      chk("j_next", fetch_addr, jal_next);

      // rdy_in low for 3 cycles in WAIT_MEM, then in HOLD
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rw_req",  {31'd0, fetch_req}, 32'd1);
         chk("rw_addr", fetch_addr, jal_next);
         chk("rw_iss",  {31'd0, ins_just_issued}, 32'd0);
      end
      rdy_in = 1'b1; csu_full = 1'b1;
      respond(32'h0070_0213);
      rdy_in = 1'b0; csu_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rh_iss", {31'd0, ins_just_issued}, 32'd0);
         chk("rh_req", {31'd0, fetch_req}, 32'd0);
         chk("rh_pc",  issue_PC, 32'h20);
      end
      rdy_in = 1'b1;
      tick();
      chk("rh_resume", {31'd0, ins_just_issued}, 32'd1);
      chk("rh_rpc",    issue_PC, jal_next);
      chk("rh_imm",    issue_imm_val, 32'd7);
      chk("rh_rd",     {27'd0, issue_rd}, 32'd4);
      tick();

      // redirect to the last word, R-type decode with zero imm, pc wraps to 0
      flush_pipline = 1'b1; flush_target_pc = 32'hFFFF_FFFC;
      tick();
      flush_pipline = 1'b0;
      respond(32'h0010_0093);
      chk("w_drop", {31'd0, ins_just_issued}, 32'd0);
      tick();
      chk("w_addr", fetch_addr, 32'hFFFF_FFFC);
      respond(32'h1234_5033);
      chk("w_iss",   {31'd0, ins_just_issued}, 32'd1);
      chk("w_imm",   issue_imm_val, 32'd0);
      chk("w_f7",    {25'd0, issue_funct7}, 32'h09);
      chk("w_rs2",   {27'd0, issue_rs2}, 32'd3);
      chk("w_shamt", {26'd0, issue_shamt_val}, 32'h23);
      chk("w_pc",    issue_PC, 32'hFFFF_FFFC);
      tick();
      chk("w_wrap",  fetch_addr, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
